ram_responder: RTL and testbench

- RAM-side end of the memory-controller/RAM interface. Receives ramREN/ramWEN/ramaddr/ramstore from the bus controller and returns ramload/ramstate with a programmable access latency.
- Holds the word-addressed backing store used by both cores' caches in simulation and FPGA builds.
- Each request handshakes to exactly one ACCESS cycle.
- A changed or dropped request aborts the access without side effects.

---
 rtl/ram_responder.sv | 155 +++++++++++++++
 tb/tb_ram_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// ram_responder: RAM-side end of the memory-controller/RAM interface.
// Holds a word-addressed backing store and answers read/write requests
// with a programmable number of BUSY cycles before a single ACCESS cycle.
//
// Ports:
//   CLK       clock, all state updates on rising edge
//   RST       synchronous active-high reset (does not clear the array)
//   ramREN    read request
//   ramWEN    write request
//   ramaddr   byte address (word aligned, below 2^(ADDR_W+2))
//   ramstore  write data, sampled only in the ACCESS cycle
//   ramload   read data, zero unless ramstate==ACCESS
//   ramstate  FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   dbg_addr  word index for backdoor read
//   dbg_data  combinational mem[dbg_addr]
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no request held; a valid request is captured here
// WAIT  | counting down BUSY cycles while the request stays unchanged
// DONE  | ACCESS cycle if the request still matches, then back to IDLE

module ram_responder #(
  parameter int LAT    = 2,
  parameter int ADDR_W = 14,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ramREN,
  input  logic              ramWEN,
  input  logic [31:0]       ramaddr,
  input  logic [WORD_W-1:0] ramstore,
  output logic [WORD_W-1:0] ramload,
  output logic [1:0]        ramstate,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WORD_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // WAIT is entered with LAT-1 so that ACCESS lands in cycle LAT+1;
  // LAT==0 skips WAIT entirely.
  localparam logic [3:0] LAT_M1 = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              cap_wr, cap_wr_n;
  logic [ADDR_W-1:0] cap_idx, cap_idx_n;
  ramstate_t         rs;
  logic              mem_we;
  logic              rd_fire;

  logic              bad_addr;
  logic              req;
  logic              err;
  logic              match;
  logic [ADDR_W-1:0] req_idx;

  assign bad_addr = (ramaddr[1:0] != 2'b00) || ((ramaddr >> (ADDR_W + 2)) != 32'd0);
  assign req      = (ramREN ^ ramWEN) && !bad_addr;
  // An idle bus with a stale address is not an error; only a request is checked.
  assign err      = (ramREN && ramWEN) || ((ramREN || ramWEN) && bad_addr);
  assign req_idx  = ramaddr[ADDR_W+1:2];
  assign match    = req && (ramWEN == cap_wr) && (req_idx == cap_idx);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      cap_wr  <= 1'b0;
      cap_idx <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cap_wr  <= cap_wr_n;
      cap_idx <= cap_idx_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cap_wr_n  = cap_wr;
    cap_idx_n = cap_idx;
    rs        = FREE;
    mem_we    = 1'b0;
    rd_fire   = 1'b0;

    if (err) begin
      rs      = ERROR;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            rs        = BUSY;
            cap_wr_n  = ramWEN;
            cap_idx_n = req_idx;
            cnt_n     = LAT_M1;
            state_n   = (LAT == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          rs = BUSY;
          if (!match) begin
            state_n = IDLE;
          end else if (cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
          end else begin
            state_n = DONE;
          end
        end
        DONE: begin
          state_n = IDLE;
          if (match) begin
            rs      = ACCESS;
            mem_we  = cap_wr;
            rd_fire = !cap_wr;
          end else begin
            rs = BUSY;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // A reset landing on the ACCESS edge aborts the write.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
      mem[cap_idx] <= ramstore;
    end
  end

  assign ramstate = rs;
  assign ramload  = rd_fire ? mem[cap_idx] : '0;
  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

  logic        CLK;
  logic        RST;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic [13:0] dbg_addr;
  logic [31:0] dbg_data;

  logic        ren0, wen0;
  logic [31:0] addr0, store0;
  logic [31:0] load0;
  logic [1:0]  state0;
  logic [13:0] dbg_addr0;
  logic [31:0] dbg_data0;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  ram_responder #(.LAT(2), .ADDR_W(14), .WORD_W(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  ram_responder #(.LAT(0), .ADDR_W(14), .WORD_W(32)) dut_lat0 (
    .CLK      (CLK),
    .RST      (RST),
    .ramREN   (ren0),
    .ramWEN   (wen0),
    .ramaddr  (addr0),
    .ramstore (store0),
    .ramload  (load0),
    .ramstate (state0),
    .dbg_addr (dbg_addr0),
    .dbg_data (dbg_data0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = 32'd0;
    ramstore = 32'd0;
  endtask

  // Holds one request until ACCESS (bounded), returns ramload seen there.
  task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, output logic [31:0] load);
    ramREN = !we;
    ramWEN = we;
    ramaddr = addr;
    ramstore = data;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ramstate == S_ACCESS) break;
      cyc();
    end
    check(tag, {30'd0, ramstate}, {30'd0, S_ACCESS});
    load = ramload;
    cyc();
    idle_bus();
  endtask

  task automatic peek(input string tag, input logic [13:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  logic [31:0] rd;

  initial begin
    RST = 1'b1;
    idle_bus();
    dbg_addr = '0;
    ren0 = 1'b0; wen0 = 1'b0; addr0 = '0; store0 = '0; dbg_addr0 = '0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_state", {30'd0, ramstate}, {30'd0, S_FREE});
    check("rst_load", ramload, 32'd0);
    check("rst_state_lat0", {30'd0, state0}, {30'd0, S_FREE});
    cyc();
    RST = 1'b0;
    cyc();

    // read latency
    do_access("preload_40", 1'b1, 32'h40, 32'hCAFEF00D, rd);
    cyc();
    ramREN = 1'b1; ramaddr = 32'h40;
    @(negedge CLK); check("rd_c0", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc();
    @(negedge CLK); check("rd_c1", {30'd0, ramstate}, {30'd0, S_BUSY});
    check("rd_c1_load", ramload, 32'd0);
    cyc();
    @(negedge CLK); check("rd_c2", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc();
    @(negedge CLK); check("rd_c3", {30'd0, ramstate}, {30'd0, S_ACCESS});
    check("rd_c3_load", ramload, 32'hCAFEF00D);
    cyc();
    ramREN = 1'b0;
    @(negedge CLK); check("rd_c4", {30'd0, ramstate}, {30'd0, S_FREE});
    check("rd_c4_load", ramload, 32'd0);
    cyc();

    // write then read; data changes during BUSY
    ramWEN = 1'b1; ramaddr = 32'h100; ramstore = 32'h0BADBAD0;
    @(negedge CLK); check("wr_c0", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc(); cyc();
    @(negedge CLK); check("wr_c2", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc();
    ramstore = 32'hDEADBEEF;
    @(negedge CLK); check("wr_c3", {30'd0, ramstate}, {30'd0, S_ACCESS});
    check("wr_c3_load", ramload, 32'd0);
    cyc();
    idle_bus();
    peek("wr_dbg_40", 14'h40, 32'hDEADBEEF);
    do_access("raw_access", 1'b0, 32'h100, 32'd0, rd);
    check("raw_load", rd, 32'hDEADBEEF);
    cyc();

    // back-to-back writeback
    ramWEN = 1'b1; ramaddr = 32'h200; ramstore = 32'h11111111;
    cyc(); cyc(); cyc();
    @(negedge CLK); check("b2b_c3", {30'd0, ramstate}, {30'd0, S_ACCESS});
    cyc();
    ramaddr = 32'h204; ramstore = 32'h22222222;
    @(negedge CLK); check("b2b_c4", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc(); cyc();
    @(negedge CLK); check("b2b_c6", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc();
    @(negedge CLK); check("b2b_c7", {30'd0, ramstate}, {30'd0, S_ACCESS});
    cyc();
    idle_bus();
    peek("b2b_dbg_80", 14'h80, 32'h11111111);
    peek("b2b_dbg_81", 14'h81, 32'h22222222);
    cyc();

    // abort by dropping the request
    do_access("preload_300", 1'b1, 32'h300, 32'h5A5A5A5A, rd);
    cyc();
    ramWEN = 1'b1; ramaddr = 32'h300; ramstore = 32'hFFFFFFFF;
    cyc(); cyc();
    ramWEN = 1'b0;
    @(negedge CLK); check("abort_c2", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc();
    @(negedge CLK); check("abort_c3", {30'd0, ramstate}, {30'd0, S_FREE});
    cyc();
    @(negedge CLK); check("abort_c4", {30'd0, ramstate}, {30'd0, S_FREE});
    peek("abort_dbg_c0", 14'hC0, 32'h5A5A5A5A);
    cyc();

    // abort by address change during WAIT
    ramWEN = 1'b1; ramaddr = 32'h300; ramstore = 32'hEEEEEEEE;
    cyc();
    ramaddr = 32'h304;
    @(negedge CLK); check("chg_c1", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc();
    @(negedge CLK); check("chg_c2", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc(); cyc();
    @(negedge CLK); check("chg_c4", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc();
    @(negedge CLK); check("chg_c5", {30'd0, ramstate}, {30'd0, S_ACCESS});
    cyc();
    idle_bus();
    peek("chg_dbg_c0", 14'hC0, 32'h5A5A5A5A);
    peek("chg_dbg_c1", 14'hC1, 32'hEEEEEEEE);
    cyc();

    // errors
    ramREN = 1'b1; ramWEN = 1'b1; ramaddr = 32'h300; ramstore = 32'h0;
    @(negedge CLK); check("err_both", {30'd0, ramstate}, {30'd0, S_ERROR});
    check("err_both_load", ramload, 32'd0);
    cyc();
    ramREN = 1'b0; ramaddr = 32'h302;
    @(negedge CLK); check("err_misalign", {30'd0, ramstate}, {30'd0, S_ERROR});
    cyc();
    ramREN = 1'b1; ramWEN = 1'b0; ramaddr = 32'h00010000;
    @(negedge CLK); check("err_range", {30'd0, ramstate}, {30'd0, S_ERROR});
    cyc();
    idle_bus();
    @(negedge CLK); check("err_recover", {30'd0, ramstate}, {30'd0, S_FREE});
    cyc();
    ramWEN = 1'b1; ramaddr = 32'h300; ramstore = 32'h77777777;
    cyc(); cyc(); cyc();
    ramREN = 1'b1;
    @(negedge CLK); check("err_in_done", {30'd0, ramstate}, {30'd0, S_ERROR});
    cyc();
    idle_bus();
    @(negedge CLK); check("err_in_done_next", {30'd0, ramstate}, {30'd0, S_FREE});
    peek("err_dbg_c0", 14'hC0, 32'h5A5A5A5A);
    cyc();

    // reset mid-write
    do_access("preload_400", 1'b1, 32'h400, 32'h13572468, rd);
    cyc();
    ramWEN = 1'b1; ramaddr = 32'h400; ramstore = 32'h99999999;
    cyc(); cyc();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    idle_bus();
    @(negedge CLK); check("rstmid_state", {30'd0, ramstate}, {30'd0, S_FREE});
    check("rstmid_load", ramload, 32'd0);
    cyc(); cyc(); cyc();
    peek("rstmid_dbg_100", 14'h100, 32'h13572468);

    // LAT=0 instance
    wen0 = 1'b1; addr0 = 32'h8; store0 = 32'h0000A5A5;
    @(negedge CLK); check("lat0_wr_c0", {30'd0, state0}, {30'd0, S_BUSY});
    cyc();
    @(negedge CLK); check("lat0_wr_c1", {30'd0, state0}, {30'd0, S_ACCESS});
    cyc();
    wen0 = 1'b0; addr0 = '0; store0 = '0;
    cyc();
    ren0 = 1'b1; addr0 = 32'h8;
    @(negedge CLK); check("lat0_rd_c0", {30'd0, state0}, {30'd0, S_BUSY});
    cyc();
    @(negedge CLK); check("lat0_rd_c1", {30'd0, state0}, {30'd0, S_ACCESS});
    check("lat0_rd_load", load0, 32'h0000A5A5);
    cyc();
    ren0 = 1'b0; addr0 = '0;
    dbg_addr0 = 14'h2;
    @(negedge CLK); check("lat0_dbg_2", dbg_data0, 32'h0000A5A5);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
